// File: rtl/write_buffer.sv
// Store FIFO between the write-through D-cache and main memory, drained in order via req/ack.
// Define WB_FORWARD_EN to build the load-forwarding comparators.
module write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              empty,
    output logic [CW-1:0]     count,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_hit,
    output logic [DATA_W-1:0] rd_data,
    output logic              mem_wr_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_wr_ack
);

    typedef enum logic {IDLE, REQ} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     head_q, tail_q;
    logic [CW-1:0]     count_q, count_d;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic              push, pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

    // REQ is only ever held with count_q != 0, so an ack there always has a head to retire
    assign push = wr_en && !full;
    assign pop  = (state_q == REQ) && mem_wr_ack;

    always_comb begin
        count_d = count_q + CW'(push) - CW'(pop);
        state_d = state_q;
        unique case (state_q)
            IDLE: if (count_q != '0 || push) state_d = REQ;
            REQ:  if (pop && count_d == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (push) tail_q <= tail_q + PW'(1);
            if (pop)  head_q <= head_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= wr_addr;
            data_q[tail_q] <= wr_data;
        end
    end

    assign mem_wr_req = (state_q == REQ);
    assign mem_addr   = mem_wr_req ? addr_q[head_q] : '0;
    assign mem_wdata  = mem_wr_req ? data_q[head_q] : '0;

`ifdef WB_FORWARD_EN
    logic [PW-1:0] idx;

    // Scan oldest to youngest so the last match (youngest) wins
    always_comb begin
        rd_hit  = 1'b0;
        rd_data = '0;
        idx     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PW'(k);
            if (CW'(k) < count_q && addr_q[idx] == rd_addr) begin
                rd_hit  = 1'b1;
                rd_data = data_q[idx];
            end
        end
    end
`else
    logic unused_rd_addr;

    assign unused_rd_addr = ^rd_addr;
    assign rd_hit         = 1'b0;
    assign rd_data        = '0;
`endif

endmodule

// File: tb/tb_write_buffer.sv
// Directed, table-driven bench for write_buffer plus multi-cycle corner sequences.
// Forwarding expectations follow WB_FORWARD_EN.
module tb_write_buffer;

    localparam logic [31:0] NA = 32'hFFFF_FFF0;

    logic        clk = 1'b0;
    logic        rst, wr_en, mem_wr_ack, rd_hit, mem_wr_req, full, empty;
    logic [31:0] wr_addr, wr_data, rd_addr, rd_data, mem_addr, mem_wdata;
    logic [2:0]  count;

    int checks   = 0;
    int failures = 0;

    write_buffer dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .full(full), .empty(empty), .count(count),
        .rd_addr(rd_addr), .rd_hit(rd_hit), .rd_data(rd_data),
        .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wr_ack(mem_wr_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, we;
        logic [31:0] wa, wd;
        logic        ack;
        logic [31:0] ra;
        logic [2:0]  cnt;
        logic [31:0] ma, md;
        logic        hit;
        logic [31:0] rdv;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic r, we, input logic [31:0] wa, wd,
                       input logic ack, input logic [31:0] ra,
                       input logic [2:0] cnt, input logic [31:0] ma, md,
                       input logic hit, input logic [31:0] rdv);
        vec_t v;
        v = '{r, we, wa, wd, ack, ra, cnt, ma, md, hit, rdv};
        vt.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, we, input logic [31:0] wa, wd,
                         input logic ack, input logic [31:0] ra);
        rst = r; wr_en = we; wr_addr = wa; wr_data = wd;
        mem_wr_ack = ack; rd_addr = ra;
    endtask

    logic [31:0] seen[$];
    logic [31:0] exp_seq[3];
    bit          fwd;

    initial begin
`ifdef WB_FORWARD_EN
        fwd = 1'b1;
`else
        fwd = 1'b0;
`endif
        drive(1, 0, 0, 0, 0, NA);
        // rst we wa wd ack ra | cnt ma md hit rdata
        add(1, 0, 0, 0, 0, NA, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, NA, 0, 0, 0, 0, 0);
        add(0, 1, 32'h0, 32'hF0F0_F0F0, 0, NA, 1, 32'h0, 32'hF0F0_F0F0, 0, 0);
        add(0, 0, 0, 0, 0, NA, 1, 32'h0, 32'hF0F0_F0F0, 0, 0);
        add(0, 0, 0, 0, 1, NA, 0, 0, 0, 0, 0);
        add(0, 1, 32'h0, 32'hA0, 0, NA, 1, 32'h0, 32'hA0, 0, 0);
        add(0, 1, 32'h4, 32'hA1, 0, NA, 2, 32'h0, 32'hA0, 0, 0);
        add(0, 1, 32'h8, 32'hA2, 0, NA, 3, 32'h0, 32'hA0, 0, 0);
        add(0, 1, 32'hC, 32'hA3, 0, NA, 4, 32'h0, 32'hA0, 0, 0);
        add(0, 1, 32'h10, 32'hA4, 0, NA, 4, 32'h0, 32'hA0, 0, 0);
        add(0, 1, 32'h10, 32'hA4, 1, NA, 3, 32'h4, 32'hA1, 0, 0);
        add(0, 0, 0, 0, 1, NA, 2, 32'h8, 32'hA2, 0, 0);
        add(0, 0, 0, 0, 1, NA, 1, 32'hC, 32'hA3, 0, 0);
        add(0, 0, 0, 0, 1, NA, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, NA, 0, 0, 0, 0, 0);
        add(0, 1, 32'h100, 32'h1, 0, 32'h100, 1, 32'h100, 32'h1, 1, 32'h1);
        add(0, 1, 32'h100, 32'h2, 0, 32'h100, 2, 32'h100, 32'h1, 1, 32'h2);
        add(0, 0, 0, 0, 0, 32'h104, 2, 32'h100, 32'h1, 0, 0);
        add(0, 0, 0, 0, 1, 32'h100, 1, 32'h100, 32'h2, 1, 32'h2);
        add(0, 0, 0, 0, 1, 32'h100, 0, 0, 0, 0, 0);
        add(0, 1, 32'h1FC, 32'h7, 0, NA, 1, 32'h1FC, 32'h7, 0, 0);
        add(0, 1, 32'h200, 32'h5, 1, NA, 1, 32'h200, 32'h5, 0, 0);
        add(0, 0, 0, 0, 1, NA, 0, 0, 0, 0, 0);
        add(0, 1, 32'h300, 32'h1, 0, NA, 1, 32'h300, 32'h1, 0, 0);
        add(0, 1, 32'h304, 32'h2, 0, NA, 2, 32'h300, 32'h1, 0, 0);
        add(0, 1, 32'h308, 32'h3, 0, NA, 3, 32'h300, 32'h1, 0, 0);
        add(1, 0, 0, 0, 1, NA, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, NA, 0, 0, 0, 0, 0);
        add(0, 1, 32'h400, 32'h9, 0, 32'h400, 1, 32'h400, 32'h9, 1, 32'h9);
        add(0, 0, 0, 0, 1, NA, 0, 0, 0, 0, 0);

        foreach (vt[i]) begin
            @(negedge clk);
            drive(vt[i].rst, vt[i].we, vt[i].wa, vt[i].wd, vt[i].ack, vt[i].ra);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d count", i), 32'(count), 32'(vt[i].cnt));
            chk($sformatf("v%0d full", i), 32'(full), 32'(vt[i].cnt == 3'd4));
            chk($sformatf("v%0d empty", i), 32'(empty), 32'(vt[i].cnt == 3'd0));
            chk($sformatf("v%0d req", i), 32'(mem_wr_req), 32'(vt[i].cnt != 3'd0));
            chk($sformatf("v%0d mem_addr", i), mem_addr, vt[i].ma);
            chk($sformatf("v%0d mem_wdata", i), mem_wdata, vt[i].md);
            chk($sformatf("v%0d rd_hit", i), 32'(rd_hit), 32'(vt[i].hit & fwd));
            chk($sformatf("v%0d rd_data", i), rd_data, fwd ? vt[i].rdv : 32'h0);
        end

        // in-flight entry still forwards right up to its ack edge
        @(negedge clk);
        drive(0, 1, 32'h500, 32'hAB, 0, NA);
        @(negedge clk);
        drive(0, 0, 0, 0, 1, 32'h500);
        #1;
        chk("inflight rd_hit", 32'(rd_hit), 32'(fwd));
        chk("inflight rd_data", rd_data, fwd ? 32'hAB : 32'h0);
        @(posedge clk);
        #1;
        chk("inflight empty", 32'(empty), 32'd1);
        chk("inflight post hit", 32'(rd_hit), 32'd0);

        // back-to-back drain with a bounded wait
        @(negedge clk);
        drive(0, 1, 32'h600, 32'h60, 0, NA);
        @(negedge clk);
        drive(0, 1, 32'h604, 32'h61, 0, NA);
        @(negedge clk);
        drive(0, 1, 32'h608, 32'h62, 0, NA);
        @(negedge clk);
        drive(0, 0, 0, 0, 1, NA);
        exp_seq = '{32'h600, 32'h604, 32'h608};
        for (int c = 0; c < 10 && !empty; c++) begin
            seen.push_back(mem_addr);
            @(negedge clk);
        end
        chk("drain done", 32'(empty), 32'd1);
        chk("drain cycles", 32'(seen.size()), 32'd3);
        for (int k = 0; k < 3; k++)
            chk($sformatf("drain addr%0d", k),
                k < seen.size() ? seen[k] : 32'hDEAD_BEEF, exp_seq[k]);
        drive(0, 0, 0, 0, 0, NA);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
